noc_output_scheduler: RTL and testbench



---
 rtl/noc_sched_pkg.sv | 15 +
 rtl/noc_output_scheduler_rr_arbiter.sv | 41 ++++
 rtl/noc_output_scheduler.sv | 151 +++++++++++++++
 tb/tb_noc_output_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_sched_pkg.sv
// Shared types and helpers for the NoC output-port scheduler.
//   sched_state_e : scheduler FSM encoding (IDLE = no owner, LOCKED = packet owns port)
//   idx_width()   : width of an encoded index into n requesters (at least 1 bit)
package noc_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_output_scheduler_rr_arbiter.sv
// Pure combinational rotating-priority picker.
//   req : request vector
//   ptr : index holding highest priority; search runs upward from ptr with wrap
//   gnt : one-hot grant of the winner (zero when no request)
//   idx : encoded winner index (zero when no request)
//   any : at least one request present
module rr_arbiter
  import noc_sched_pkg::*;
#(
  parameter  int N = 5,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  int j;

  // Walk offsets from farthest to nearest so the requester closest to ptr
  // is the last one written and therefore wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int off = N - 1; off >= 0; off--) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_scheduler.sv
// Per-output-port scheduler: round-robin arbitration with wormhole locking
// and credit-based flow control towards the downstream flit buffer.
//   clk, rst_n    : clk_noc clock, asynchronous active-low reset
//   req           : input i holds a flit routed to this output
//   is_tail       : flit at input i is a packet tail
//   disable_turn  : input i may not use this output
//   credit_in     : downstream freed one buffer slot
//   grant         : one-hot, combinational; input i's flit is sent this cycle
//   send_out      : a flit is sent this cycle
//   sel           : crossbar mux select (granted input, else owner, else 0)
//   locked        : a packet currently owns the output
//   credits       : current credit count
//   credit_err    : sticky credit overflow flag
//   dbg_state     : FSM state, for observation
//   dbg_ptr       : round-robin pointer, for observation
//
// Handshake: a flit moves when grant[i] is high in a cycle; the input side
// treats grant as its ready and must present the next flit (or drop req) by
// the following cycle. There is no back-pressure on send_out other than credits.
module noc_output_scheduler
  import noc_sched_pkg::*;
#(
  parameter  int NUM_INPUTS        = 5,
  parameter  int FLIT_BUFFER_DEPTH = 1,
  parameter  int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
  localparam int IDX_W             = idx_width(NUM_INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_INPUTS-1:0]   req,
  input  logic [NUM_INPUTS-1:0]   is_tail,
  input  logic [NUM_INPUTS-1:0]   disable_turn,
  input  logic                    credit_in,
  output logic [NUM_INPUTS-1:0]   grant,
  output logic                    send_out,
  output logic [IDX_W-1:0]        sel,
  output logic                    locked,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    credit_err,
  output sched_state_e            dbg_state,
  output logic [IDX_W-1:0]        dbg_ptr
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(NUM_INPUTS - 1);

  sched_state_e            state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [CREDIT_WIDTH-1:0] credits_q;
  logic                    credit_err_q;

  logic [NUM_INPUTS-1:0]   eff_req;
  logic [NUM_INPUTS-1:0]   grant_c;
  logic [NUM_INPUTS-1:0]   arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic                    credit_ok;
  logic [IDX_W-1:0]        sel_c;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  assign eff_req   = req & ~disable_turn;
  assign credit_ok = (credits_q != '0);

  rr_arbiter #(.N(NUM_INPUTS)) u_arb (
    .req (eff_req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_c = '0;
    sel_c   = '0;
    unique case (state_q)
      IDLE: begin
        if (credit_ok && arb_any) begin
          grant_c = arb_gnt;
          sel_c   = arb_idx;
          if (is_tail[arb_idx]) begin
            ptr_d = next_idx(arb_idx);
          end else begin
            state_d = LOCKED;
            owner_d = arb_idx;
          end
        end
      end
      LOCKED: begin
        // Only the owner may send; a missing owner flit is a bubble and the
        // lock holds (this also covers a disable_turn raised mid-packet).
        sel_c = owner_q;
        if (credit_ok && eff_req[owner_q]) begin
          grant_c[owner_q] = 1'b1;
          if (is_tail[owner_q]) begin
            state_d = IDLE;
            ptr_d   = next_idx(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // No flit leaves while reset is held, even though state is already at IDLE.
  assign grant    = rst_n ? grant_c : '0;
  assign send_out = |grant;
  assign sel      = send_out ? sel_c : ((state_q == LOCKED) ? owner_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q    <= CREDIT_MAX;
      credit_err_q <= 1'b0;
    end else begin
      if (send_out && !credit_in) begin
        credits_q <= credits_q - 1'b1;
      end else if (credit_in && !send_out) begin
        if (credits_q == CREDIT_MAX) begin
          credit_err_q <= 1'b1;
        end else begin
          credits_q <= credits_q + 1'b1;
        end
      end
    end
  end

  assign locked     = (state_q == LOCKED);
  assign credits    = credits_q;
  assign credit_err = credit_err_q;
  assign dbg_state  = state_q;
  assign dbg_ptr    = ptr_q;

endmodule

// File: tb/tb_noc_output_scheduler.sv
module tb_noc_output_scheduler;
  import noc_sched_pkg::*;

  localparam int N     = 5;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  is_tail = '0;
  logic [N-1:0]  disable_turn = '0;
  logic          credit_in = 1'b0;
  logic [N-1:0]  grant;
  logic          send_out;
  logic [IW-1:0] sel;
  logic          locked;
  logic [CW-1:0] credits;
  logic          credit_err;
  sched_state_e  dbg_state;
  logic [IW-1:0] dbg_ptr;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] e;

  noc_output_scheduler #(
    .NUM_INPUTS       (N),
    .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .is_tail     (is_tail),
    .disable_turn(disable_turn),
    .credit_in   (credit_in),
    .grant       (grant),
    .send_out    (send_out),
    .sel         (sel),
    .locked      (locked),
    .credits     (credits),
    .credit_err  (credit_err),
    .dbg_state   (dbg_state),
    .dbg_ptr     (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; is_tail = '0; disable_turn = '0; credit_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of stimulus at the falling edge, records the expected
  // grant, and leaves time 1 unit later so outputs can be sampled.
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] t,
                       input logic [N-1:0] d, input logic c,
                       input logic [N-1:0] exp_g);
    @(negedge clk);
    req = r; is_tail = t; disable_turn = d; credit_in = c;
    exp_q.push_back(exp_g);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '1;
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (grant !== e) begin errors++; $display("FAIL reset_grant got %b exp %b", grant, e); end
    checks++;
    if (credits !== CW'(DEPTH)) begin errors++; $display("FAIL reset_credits got %0d exp %0d", credits, DEPTH); end
    checks++;
    if (locked !== 1'b0 || credit_err !== 1'b0 || dbg_ptr !== '0 || sel !== '0) begin
      errors++;
      $display("FAIL reset_state got locked=%b err=%b ptr=%0d sel=%0d exp all 0", locked, credit_err, dbg_ptr, sel);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  r_t[6]  = '{5'b00110, 5'b00110, 5'b00110, 5'b00110, 5'b00110, 5'b00000};
    logic [N-1:0]  t_t[6]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00100, 5'b00000};
    logic          c_t[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [N-1:0]  g_t[6]  = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00100, 5'b00000};
    logic [IW-1:0] p_t[6]  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd3};
    logic          l_t[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(r_t[i], t_t[i], '0, c_t[i], g_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (grant !== e) begin errors++; $display("FAIL rr_grant cyc%0d got %b exp %b", i, grant, e); end
      checks++;
      if (dbg_ptr !== p_t[i] || locked !== l_t[i]) begin
        errors++;
        $display("FAIL rr_state cyc%0d got ptr=%0d locked=%b exp ptr=%0d locked=%b", i, dbg_ptr, locked, p_t[i], l_t[i]);
      end
    end
  endtask

  task automatic test_credit_exhaust();
    logic          c_t[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [N-1:0]  g_t[8] = '{5'b00001, 5'b00001, 5'b0, 5'b0, 5'b0, 5'b0, 5'b00001, 5'b0};
    logic [CW-1:0] k_t[8] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(5'b00001, '0, '0, c_t[i], g_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (grant !== e || credits !== k_t[i]) begin
        errors++;
        $display("FAIL credit_exhaust cyc%0d got grant=%b credits=%0d exp grant=%b credits=%0d", i, grant, credits, e, k_t[i]);
      end
    end
  endtask

  // Continues from the exhausted state left by test_credit_exhaust.
  task automatic test_simultaneous_credit();
    drive(5'b00001, '0, '0, 1'b1, 5'b00000);
    e = exp_q.pop_front();
    checks++;
    if (grant !== e) begin errors++; $display("FAIL simul_refill got %b exp %b", grant, e); end
    for (int i = 0; i < 4; i++) begin
      drive(5'b00001, (i == 3) ? 5'b00001 : 5'b0, '0, 1'b1, 5'b00001);
      e = exp_q.pop_front();
      checks++;
      if (grant !== e || credits !== 2'd1) begin
        errors++;
        $display("FAIL simul_send cyc%0d got grant=%b credits=%0d exp grant=%b credits=1", i, grant, credits, e);
      end
    end
    drive('0, '0, '0, 1'b0, '0);
    exp_q.pop_front();
    checks++;
    if (locked !== 1'b0 || dbg_ptr !== 3'd1 || credits !== 2'd1) begin
      errors++;
      $display("FAIL simul_end got locked=%b ptr=%0d credits=%0d exp 0/1/1", locked, dbg_ptr, credits);
    end
  endtask

  task automatic test_disable_turn();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(5'b01000, '0, 5'b01000, 1'b0, 5'b00000);
      e = exp_q.pop_front();
      checks++;
      if (grant !== e || locked !== 1'b0) begin
        errors++;
        $display("FAIL disable_block cyc%0d got grant=%b locked=%b exp grant=%b locked=0", i, grant, locked, e);
      end
    end
    drive(5'b01000, 5'b01000, '0, 1'b0, 5'b01000);
    e = exp_q.pop_front();
    checks++;
    if (grant !== e || sel !== 3'd3) begin
      errors++;
      $display("FAIL disable_clear got grant=%b sel=%0d exp grant=%b sel=3", grant, sel, e);
    end
  endtask

  task automatic test_owner_bubble();
    logic [N-1:0] r_t[6] = '{5'b10001, 5'b10000, 5'b10000, 5'b10001, 5'b10001, 5'b10000};
    logic [N-1:0] t_t[6] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b10000};
    logic [N-1:0] g_t[6] = '{5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b10000};
    logic         s_t[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic         l_t[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [IW-1:0] x_t[6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(r_t[i], t_t[i], '0, 1'b1, g_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (grant !== e || send_out !== s_t[i] || locked !== l_t[i] || sel !== x_t[i]) begin
        errors++;
        $display("FAIL owner_bubble cyc%0d got grant=%b send=%b locked=%b sel=%0d exp %b/%b/%b/%0d",
                 i, grant, send_out, locked, sel, e, s_t[i], l_t[i], x_t[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive(5'b00100, '0, '0, 1'b0, 5'b00100);
    e = exp_q.pop_front();
    checks++;
    if (grant !== e) begin errors++; $display("FAIL rst_mid_head got %b exp %b", grant, e); end
    drive(5'b00100, '0, '0, 1'b0, 5'b00100);
    exp_q.pop_front();
    drive(5'b00100, '0, '0, 1'b0, 5'b00000);
    e = exp_q.pop_front();
    checks++;
    if (grant !== e || credits !== 2'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre got grant=%b credits=%0d locked=%b exp %b/0/1", grant, credits, locked, e);
    end
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (grant !== e || locked !== 1'b0 || credits !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL rst_mid_abort got grant=%b locked=%b credits=%0d exp %b/0/%0d", grant, locked, credits, e, DEPTH);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = '0;
    drive('0, '0, '0, 1'b1, '0);
    exp_q.pop_front();
    for (int i = 0; i < 2; i++) begin
      drive('0, '0, '0, 1'b0, '0);
      exp_q.pop_front();
      checks++;
      if (credit_err !== 1'b1 || credits !== CW'(DEPTH)) begin
        errors++;
        $display("FAIL credit_overflow cyc%0d got err=%b credits=%0d exp 1/%0d", i, credit_err, credits, DEPTH);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_round_robin();
    test_credit_exhaust();
    test_simultaneous_credit();
    test_disable_turn();
    test_owner_bubble();
    test_reset_mid_packet();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
